// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, converter state encoding and the position-count
// helper for the seg_scan_mux display scanner.
package seg_pkg;

    // Nibble codes understood by the board's 7-segment decoder.
    localparam logic [3:0] SEP_CODE_DEF   = 4'hF;
    localparam logic [3:0] BLANK_CODE_DEF = 4'hA;

    // Converter sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        NEXT,
        COMMIT
    } conv_state_t;

    // Two digits per field plus one separator between neighbouring fields.
    function automatic int ndig(input int fields);
        return 3 * fields - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary to BCD converter, one bit per
// clock.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : load i_bin and begin converting (ignored bits are cleared)
//   i_bin        : binary value to convert
//   o_done       : high during the final shift cycle; o_bcd/o_ovf are valid
//                  from the following cycle until the next i_start
//   o_bcd        : {tens, units} BCD digits
//   o_ovf        : value was above 99 (hundreds digit or beyond non-zero)
module bin2bcd_seq #(
    parameter int FIELD_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [FIELD_W-1:0] i_bin,
    output logic               o_done,
    output logic [7:0]         o_bcd,
    output logic               o_ovf
);

    localparam int CW = $clog2(FIELD_W);

    logic [FIELD_W-1:0] r_sh;
    logic [11:0]        r_bcd;
    logic               r_sticky;
    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [11:0]        w_adj;
    logic               w_last;

    // Add 3 to every nibble that would reach 10 or more after the shift.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                      r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
        end
    endgenerate

    assign w_last = r_busy && (r_cnt == CW'(FIELD_W - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh     <= '0;
            r_bcd    <= '0;
            r_sticky <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_sh     <= i_bin;
            r_bcd    <= '0;
            r_sticky <= 1'b0;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
        end else if (r_busy) begin
            r_bcd    <= {w_adj[10:0], r_sh[FIELD_W-1]};
            r_sh     <= {r_sh[FIELD_W-2:0], 1'b0};
            // Only three nibbles are kept; a carry out of the hundreds
            // digit means the value reached 1000 and must still flag ovf.
            r_sticky <= r_sticky | w_adj[11];
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done = w_last;
    assign o_bcd  = r_bcd[7:0];
    assign o_ovf  = r_sticky | (r_bcd[11:8] != 4'd0);

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed 7-segment scanner for FIELDS binary fields.
//   clk1000  : scan/system clock
//   rst      : synchronous active-high reset
//   bus      : packed fields, field FIELDS-1 (MSBs) shown leftmost
//   blink_en : per-field blink enable
//   num      : BCD digit, separator or blank code for the current position
//   wx       : active-low one-cold digit enables, MSB = leftmost position
//   ovf      : per-field "value above 99" from the last commit
//   frame    : one-cycle pulse while position 0 is being driven
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int         FIELDS      = 3,
    parameter int         FIELD_W     = 8,
    parameter int         DIV         = 1,
    parameter int         BLINK_TICKS = 250,
    parameter logic [3:0] SEP_CODE    = SEP_CODE_DEF,
    parameter logic [3:0] BLANK_CODE  = BLANK_CODE_DEF,
    localparam int        NDIG        = ndig(FIELDS)
) (
    input  logic                      clk1000,
    input  logic                      rst,
    input  logic [FIELDS*FIELD_W-1:0] bus,
    input  logic [FIELDS-1:0]         blink_en,
    output logic [3:0]                num,
    output logic [NDIG-1:0]           wx,
    output logic [FIELDS-1:0]         ovf,
    output logic                      frame
);

    localparam int FW   = $clog2(FIELDS + 1);
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int POSW = $clog2(NDIG);

    // ---------------- converter sequencing ----------------
    conv_state_t               r_state, w_state_next;
    logic [FIELDS*FIELD_W-1:0] r_shadow;
    logic [FW-1:0]             r_f;
    logic [FW-1:0]             w_f_inc;
    logic [FIELDS*8-1:0]       r_stage, r_com;
    logic [FIELDS-1:0]         r_stage_ovf, r_com_ovf;
    logic                      w_start;
    logic [FIELD_W-1:0]        w_start_val;
    logic                      w_core_done;
    logic [7:0]                w_core_bcd;
    logic                      w_core_ovf;
    logic [FIELD_W-1:0]        w_shadow_field [FIELDS];

    generate
        for (genvar gi = 0; gi < FIELDS; gi++) begin : g_fields
            assign w_shadow_field[gi] = r_shadow[gi*FIELD_W +: FIELD_W];
        end
    endgenerate

    assign w_f_inc = r_f + FW'(1);

    bin2bcd_seq #(.FIELD_W(FIELD_W)) u_core (
        .i_clk   (clk1000),
        .i_rst   (rst),
        .i_start (w_start),
        .i_bin   (w_start_val),
        .o_done  (w_core_done),
        .o_bcd   (w_core_bcd),
        .o_ovf   (w_core_ovf)
    );

    // Field 0 is started straight from the bus in the same cycle the shadow
    // captures it, so both see the identical snapshot.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_start_val  = '0;
        case (r_state)
            IDLE: begin
                w_state_next = LOAD;
                w_start      = 1'b1;
                w_start_val  = bus[FIELD_W-1:0];
            end
            LOAD:  w_state_next = SHIFT;
            SHIFT: if (w_core_done) w_state_next = NEXT;
            NEXT: begin
                if (r_f == FW'(FIELDS - 1)) begin
                    w_state_next = COMMIT;
                end else begin
                    w_state_next = SHIFT;
                    w_start      = 1'b1;
                    for (int i = 0; i < FIELDS; i++) begin
                        if (w_f_inc == FW'(i)) w_start_val = w_shadow_field[i];
                    end
                end
            end
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1000) begin
        if (rst) begin
            r_state     <= IDLE;
            r_f         <= '0;
            r_shadow    <= '0;
            r_stage     <= '0;
            r_stage_ovf <= '0;
            r_com       <= '0;
            r_com_ovf   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    r_shadow <= bus;
                    r_f      <= '0;
                end
                NEXT: begin
                    for (int i = 0; i < FIELDS; i++) begin
                        if (r_f == FW'(i)) begin
                            r_stage[i*8 +: 8] <= w_core_ovf ? 8'h99 : w_core_bcd;
                            r_stage_ovf[i]    <= w_core_ovf;
                        end
                    end
                    r_f <= w_f_inc;
                end
                COMMIT: begin
                    r_com     <= r_stage;
                    r_com_ovf <= r_stage_ovf;
                end
                default: ;
            endcase
        end
    end

    // ---------------- scan ----------------
    logic [PW-1:0]   r_pre;
    logic [POSW-1:0] r_pos;
    logic [BW-1:0]   r_bcnt;
    logic            r_phase;
    logic [3:0]      r_num;
    logic [NDIG-1:0] r_wx;
    logic            r_frame;
    logic            w_tick;
    logic [FW-1:0]   w_fld;
    logic [1:0]      w_sub;
    logic [3:0]      w_num_next;
    logic [NDIG-1:0] w_wx_next;

    assign w_tick = (r_pre == PW'(DIV - 1));

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_wx
            assign w_wx_next[gi] = (r_pos != POSW'(NDIG - 1 - gi));
        end
    endgenerate

    always_comb begin
        w_fld = FW'(FIELDS - 1 - int'(r_pos) / 3);
        w_sub = 2'(int'(r_pos) % 3);
        if (w_sub == 2'd2) begin
            w_num_next = SEP_CODE;
        end else if (r_phase && blink_en[w_fld]) begin
            w_num_next = BLANK_CODE;
        end else if (w_sub == 2'd0) begin
            w_num_next = r_com[int'(w_fld)*8 + 4 +: 4];
        end else begin
            w_num_next = r_com[int'(w_fld)*8 +: 4];
        end
    end

    always_ff @(posedge clk1000) begin
        if (rst) begin
            r_pre   <= '0;
            r_pos   <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
            r_num   <= BLANK_CODE;
            r_wx    <= '1;
            r_frame <= 1'b0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + PW'(1);
            r_frame <= 1'b0;
            if (w_tick) begin
                r_num   <= w_num_next;
                r_wx    <= w_wx_next;
                r_frame <= (r_pos == '0);
                r_pos   <= (r_pos == POSW'(NDIG - 1)) ? '0 : r_pos + POSW'(1);
                if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + BW'(1);
                end
            end
        end
    end

    assign num   = r_num;
    assign wx    = r_wx;
    assign frame = r_frame;
    assign ovf   = r_com_ovf;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

    localparam int FIELDS = 3;
    localparam int NDIG   = 8;
    localparam int PERIOD = 29;   // FIELDS*(FIELD_W+1)+2 conversion cycle

    logic        clk1000 = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] bus = '0;
    logic [2:0]  blink_en = '0;
    logic [3:0]  num_a, num_b;
    logic [7:0]  wx_a, wx_b;
    logic [2:0]  ovf_a, ovf_b;
    logic        frame_a, frame_b;

    int checks = 0;
    int errors = 0;

    always #5 clk1000 = ~clk1000;

    seg_scan_mux #(.DIV(1), .BLINK_TICKS(2)) dut_a (
        .clk1000(clk1000), .rst(rst), .bus(bus), .blink_en(blink_en),
        .num(num_a), .wx(wx_a), .ovf(ovf_a), .frame(frame_a)
    );

    seg_scan_mux #(.DIV(4), .BLINK_TICKS(3)) dut_b (
        .clk1000(clk1000), .rst(rst), .bus(bus), .blink_en(blink_en),
        .num(num_b), .wx(wx_b), .ovf(ovf_b), .frame(frame_b)
    );

    // ---------------- reference model ----------------
    // Conversion works on whole-frame snapshots: the bus seen on edge 1 after
    // reset (and every PERIOD edges later) becomes visible on edge PERIOD.
    // Each tick n displays position n mod NDIG from the committed digits.
    int          cyc = 0;
    int          div_c [2] = '{1, 4};
    int          bt_c  [2] = '{2, 3};
    logic [3:0]  exp_num [2];
    logic [7:0]  exp_wx [2];
    logic        exp_frame [2];
    logic [2:0]  exp_ovf;
    int          m_tens [3];
    int          m_units [3];
    logic [23:0] snap;

    always @(posedge clk1000) begin : model
        int n, p, f, s, ph, v;
        if (rst) begin
            cyc = 0;
            exp_ovf = '0;
            for (int d = 0; d < 2; d++) begin
                exp_num[d] = 4'hA; exp_wx[d] = 8'hFF; exp_frame[d] = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                m_tens[k] = 0; m_units[k] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int d = 0; d < 2; d++) begin
                if (cyc % div_c[d] == 0) begin
                    n  = cyc / div_c[d] - 1;
                    p  = n % NDIG;
                    f  = FIELDS - 1 - p / 3;
                    s  = p % 3;
                    ph = (n / bt_c[d]) % 2;
                    exp_wx[d]    = ~(8'h80 >> p);
                    exp_frame[d] = (p == 0);
                    if (s == 2)                      exp_num[d] = 4'hF;
                    else if (ph == 1 && blink_en[f]) exp_num[d] = 4'hA;
                    else if (s == 0)                 exp_num[d] = 4'(m_tens[f]);
                    else                             exp_num[d] = 4'(m_units[f]);
                end else begin
                    exp_frame[d] = 1'b0;
                end
            end
            if (cyc % PERIOD == 0) begin
                for (int k = 0; k < 3; k++) begin
                    v = int'(snap[k*8 +: 8]);
                    exp_ovf[k] = (v > 99);
                    m_tens[k]  = (v > 99) ? 9 : v / 10;
                    m_units[k] = (v > 99) ? 9 : v % 10;
                end
            end
            if (cyc % PERIOD == 1) snap = bus;
        end
    end

    logic [3:0] seq_num [8] = '{4'h1, 4'h2, 4'hF, 4'h3, 4'h4, 4'hF, 4'h5, 4'h6};
    logic [7:0] seq_wx  [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit found;
        rst = 1'b1; bus = 24'h0C2238; blink_en = '0;
        repeat (3) begin
            @(negedge clk1000);
            checks += 2;
            if ({num_a, wx_a, frame_a, ovf_a} !== {4'hA, 8'hFF, 1'b0, 3'b000}) begin
                errors++;
                $display("FAIL reset_a num=%h wx=%h frame=%b ovf=%b want A FF 0 000", num_a, wx_a, frame_a, ovf_a);
            end
            if ({num_b, wx_b, frame_b, ovf_b} !== {4'hA, 8'hFF, 1'b0, 3'b000}) begin
                errors++;
                $display("FAIL reset_b num=%h wx=%h frame=%b ovf=%b want A FF 0 000", num_b, wx_b, frame_b, ovf_b);
            end
        end
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk1000);
            if (cyc > PERIOD && frame_a) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL first_frame no frame pulse after first commit within 100 cycles");
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if ({num_a, wx_a, frame_a} !== {seq_num[k], seq_wx[k], (k == 0)}) begin
                    errors++;
                    $display("FAIL first_frame pos=%0d num=%h wx=%h frame=%b want %h %h %b",
                             k, num_a, wx_a, frame_a, seq_num[k], seq_wx[k], (k == 0));
                end
                @(negedge clk1000);
            end
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            bus = 24'($urandom); blink_en = 3'($urandom);
            repeat (70) begin
                @(negedge clk1000);
                checks += 2;
                if ({num_a, wx_a, frame_a, ovf_a} !== {exp_num[0], exp_wx[0], exp_frame[0], exp_ovf}) begin
                    errors++;
                    $display("FAIL random_a cyc=%0d got %h %h %b %b want %h %h %b %b", cyc, num_a, wx_a, frame_a, ovf_a, exp_num[0], exp_wx[0], exp_frame[0], exp_ovf);
                end
                if ({num_b, wx_b, frame_b, ovf_b} !== {exp_num[1], exp_wx[1], exp_frame[1], exp_ovf}) begin
                    errors++;
                    $display("FAIL random_b cyc=%0d got %h %h %b %b want %h %h %b %b", cyc, num_b, wx_b, frame_b, ovf_b, exp_num[1], exp_wx[1], exp_frame[1], exp_ovf);
                end
            end
            $display("test_random bus=%h blink_en=%b checks=%0d errors=%0d", bus, blink_en, checks, errors);
        end
    endtask

    task automatic test_overflow();
        bus = {8'd255, 8'd7, 8'd7}; blink_en = '0;
        repeat (70) begin
            @(negedge clk1000);
            checks++;
            if ({num_a, wx_a, frame_a, ovf_a} !== {exp_num[0], exp_wx[0], exp_frame[0], exp_ovf}) begin
                errors++;
                $display("FAIL overflow_a cyc=%0d got %h %h %b %b want %h %h %b %b", cyc, num_a, wx_a, frame_a, ovf_a, exp_num[0], exp_wx[0], exp_frame[0], exp_ovf);
            end
        end
        checks += 2;
        if (ovf_a !== 3'b100) begin
            errors++;
            $display("FAIL overflow_flag_a ovf=%b want 100", ovf_a);
        end
        if (ovf_b !== 3'b100) begin
            errors++;
            $display("FAIL overflow_flag_b ovf=%b want 100", ovf_b);
        end
        $display("test_overflow bus=%h checks=%0d errors=%0d", bus, checks, errors);
    endtask

    task automatic test_div4();
        logic [7:0] prev;
        int run;
        bit started;
        bus = 24'($urandom); blink_en = 3'($urandom);
        prev = wx_b; run = 0; started = 1'b0;
        repeat (160) begin
            @(negedge clk1000);
            checks++;
            if ({num_b, wx_b, frame_b, ovf_b} !== {exp_num[1], exp_wx[1], exp_frame[1], exp_ovf}) begin
                errors++;
                $display("FAIL div4_model cyc=%0d got %h %h %b %b want %h %h %b %b", cyc, num_b, wx_b, frame_b, ovf_b, exp_num[1], exp_wx[1], exp_frame[1], exp_ovf);
            end
            checks++;
            if ($countones(~wx_b) != 1) begin
                errors++;
                $display("FAIL div4_onecold wx=%h want exactly one low bit", wx_b);
            end
            if (wx_b == prev) begin
                run++;
            end else begin
                if (started) begin
                    checks++;
                    if (run != 4) begin
                        errors++;
                        $display("FAIL div4_persist wx=%h held %0d cycles want 4", prev, run);
                    end
                end
                started = 1'b1;
                run = 1;
                prev = wx_b;
            end
        end
        $display("test_div4 checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_blink();
        bus = 24'h0C2238; blink_en = 3'b010;
        repeat (80) begin
            @(negedge clk1000);
            checks++;
            if ({num_a, wx_a, frame_a, ovf_a} !== {exp_num[0], exp_wx[0], exp_frame[0], exp_ovf}) begin
                errors++;
                $display("FAIL blink_model cyc=%0d got %h %h %b %b want %h %h %b %b", cyc, num_a, wx_a, frame_a, ovf_a, exp_num[0], exp_wx[0], exp_frame[0], exp_ovf);
            end
            if (wx_a == 8'hDF || wx_a == 8'hFB) begin
                checks++;
                if (num_a !== 4'hF) begin
                    errors++;
                    $display("FAIL blink_sep wx=%h num=%h want F", wx_a, num_a);
                end
            end
            if (wx_a == 8'hEF) begin
                checks++;
                if (num_a !== 4'h3 && num_a !== 4'hA) begin
                    errors++;
                    $display("FAIL blink_tens num=%h want 3 or A", num_a);
                end
            end
        end
        $display("test_blink checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_tear();
        blink_en = '0;
        repeat (150) begin
            @(negedge clk1000);
            checks += 2;
            if ({num_a, wx_a, frame_a, ovf_a} !== {exp_num[0], exp_wx[0], exp_frame[0], exp_ovf}) begin
                errors++;
                $display("FAIL tear_a cyc=%0d got %h %h %b %b want %h %h %b %b", cyc, num_a, wx_a, frame_a, ovf_a, exp_num[0], exp_wx[0], exp_frame[0], exp_ovf);
            end
            if ({num_b, wx_b, frame_b, ovf_b} !== {exp_num[1], exp_wx[1], exp_frame[1], exp_ovf}) begin
                errors++;
                $display("FAIL tear_b cyc=%0d got %h %h %b %b want %h %h %b %b", cyc, num_b, wx_b, frame_b, ovf_b, exp_num[1], exp_wx[1], exp_frame[1], exp_ovf);
            end
            bus = 24'($urandom);
        end
        $display("test_tear checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid();
        bit found;
        bus = {8'd200, 8'd150, 8'd99}; blink_en = 3'b111;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk1000);
            if (cyc % PERIOD == 12) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_wait did not reach mid-conversion within 40 cycles");
        end
        rst = 1'b1;
        @(negedge clk1000);
        checks += 2;
        if ({num_a, wx_a, frame_a, ovf_a} !== {4'hA, 8'hFF, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid_a num=%h wx=%h frame=%b ovf=%b want A FF 0 000", num_a, wx_a, frame_a, ovf_a);
        end
        if ({num_b, wx_b, frame_b, ovf_b} !== {4'hA, 8'hFF, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid_b num=%h wx=%h frame=%b ovf=%b want A FF 0 000", num_b, wx_b, frame_b, ovf_b);
        end
        rst = 1'b0; bus = {8'd42, 8'd8, 8'd61}; blink_en = '0;
        repeat (80) begin
            @(negedge clk1000);
            checks += 2;
            if ({num_a, wx_a, frame_a, ovf_a} !== {exp_num[0], exp_wx[0], exp_frame[0], exp_ovf}) begin
                errors++;
                $display("FAIL reset_mid_run_a cyc=%0d got %h %h %b %b want %h %h %b %b", cyc, num_a, wx_a, frame_a, ovf_a, exp_num[0], exp_wx[0], exp_frame[0], exp_ovf);
            end
            if ({num_b, wx_b, frame_b, ovf_b} !== {exp_num[1], exp_wx[1], exp_frame[1], exp_ovf}) begin
                errors++;
                $display("FAIL reset_mid_run_b cyc=%0d got %h %h %b %b want %h %h %b %b", cyc, num_b, wx_b, frame_b, ovf_b, exp_num[1], exp_wx[1], exp_frame[1], exp_ovf);
            end
        end
        $display("test_reset_mid checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_random();
        test_overflow();
        test_div4();
        test_blink();
        test_tear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
